settle_checker: RTL
===================

Name: settle_checker

Overview:
- Synchronous receive-side checker for the gate-level and-or lab circuit, whose function is out = (a&b)|c.
- Watches the 3-bit stimulus vector driven into the circuit and the circuit's output.
- On every stimulus change it measures how many clock cycles the output takes to settle to the expected value. It then reports pass/fail and latency, and keeps running statistics.
- Sits beside the device under test on the lab board/bench, opposite the stimulus generator.

Parameters:
- SETTLE_CYC, 2: consecutive cycles dut_out must equal the expected value to qualify (≥1).
- TIMEOUT_CYC, 15: maximum measurement index before declaring timeout (> SETTLE_CYC, < 2^LAT_W).
- LAT_W, 4: width of latency outputs.
- CNT_W, 8: width of statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_a  in  1  stimulus bit a, as applied to the device under test.
- in_b  in  1  stimulus bit b.
- in_c  in  1  stimulus bit c.
- dut_out  in  1  device-under-test output.
- chk_valid  out  1  one-cycle pulse: a result is presented.
- chk_pass  out  1  result: settled correctly; valid with chk_valid.
- chk_lat  out  LAT_W  measured settle latency (cycles); valid with chk_valid.
- err_timeout  out  1  result: no qualifying run by TIMEOUT_CYC; valid with chk_valid.
- err_abort  out  1  result: stimulus changed before settling; valid with chk_valid.
- vec_cnt  out  CNT_W  vectors measured, saturating.
- fail_cnt  out  CNT_W  failed vectors, saturating.
- max_lat  out  LAT_W  largest passing latency since reset.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - During rst, all outputs are 0, the state is IDLE, and vec_q <= {in_a,in_b,in_c}. Releasing reset with unchanged inputs therefore produces no event.
  - rst mid-measurement discards the measurement with no report.
- vec_q is registered every cycle. change = ({in_a,in_b,in_c} != vec_q). The change cycle is index 0.
- On change: exp <= (in_a&in_b)|in_c, idx <= 1, run <= 0; go to MEAS.
- The expected value is computed from the live inputs in the change cycle, not from vec_q.
- States:
  - IDLE: wait for change.
  - MEAS: each cycle, sample dut_out at the current idx.
    - If dut_out == exp: run++. When run was 0, also set mark <= idx.
    - Otherwise run <= 0.
    - Qualify when run reaches SETTLE_CYC, i.e. on the SETTLE_CYC-th consecutive match, including the current cycle.
    - Qualify → registered report next cycle: chk_valid=1, chk_pass=1, chk_lat=mark. Return to IDLE.
    - Timeout when idx == TIMEOUT_CYC without qualifying → report chk_pass=0, err_timeout=1, chk_lat=TIMEOUT_CYC. Go to IDLE.
    - Change while in MEAS without qualify/timeout in that cycle → report chk_pass=0, err_abort=1, chk_lat=idx. Restart MEAS for the new vector (new exp, idx=1).
- Simultaneous events:
  - Qualify and change in the same cycle: report pass for the old vector, then start a new MEAS.
  - Timeout and change in the same cycle: report timeout, then start a new MEAS.
  - At most one report per cycle.
- Report outputs: chk_valid, chk_pass, err_* and chk_lat are registered. All are 0 except in the report cycle. chk_lat holds its last value.
- Counters (update in the report cycle):
  - vec_cnt +1 per report.
  - fail_cnt +1 when chk_pass=0.
  - Both saturate at all-ones; no wrap.
  - max_lat <= max(max_lat, chk_lat) on pass only.
- Widths: idx saturates at TIMEOUT_CYC; run saturates at SETTLE_CYC. No arithmetic overflow is possible.

Decomposition:
- Shared package settle_pkg holds:
  - MEAS/IDLE state constants.
  - Default SETTLE_CYC/TIMEOUT_CYC.
  - Function ref_out(a,b,c) = (a&b)|c.
- One natural sub-module: settle_ref, the combinational expected-value generator. It is swappable for other lab circuits.
- All state, counters and reporting stay in settle_checker.

Test Plan (SETTLE_CYC=2, TIMEOUT_CYC=15; the bench models the device under test as a programmable N-cycle delay):
- Reset with abc=000, release, hold 10 cycles → no chk_valid; vec_cnt=fail_cnt=max_lat=0.
- 000→111, delay 3 → dut_out 1 from idx 3. chk_valid at idx 5 with pass=1, chk_lat=3. vec_cnt=1, max_lat=3.
- 111→100 with dut_out stuck at 1 (exp=0) → report at idx 16: pass=0, err_timeout=1, chk_lat=15, fail_cnt=1.
- exp=1, dut_out=1 at idx 2, 0 at idx 3, 1 from idx 4 → pass, chk_lat=4 (glitch restarts the run).
- Change at idx 2 of a measurement → abort report (pass=0, err_abort=1, chk_lat=2). The new vector then passes. vec_cnt +2, fail_cnt +1.
- rst asserted at idx 3 for 1 cycle, inputs unchanged → no report; counters 0; no spurious event after release.

Source files
------------

// File: rtl/settle_pkg.sv
// Shared definitions for the settle checker.
// Holds the checker state encoding, the default measurement parameters and
// the reference function of the lab circuit under test: out = (a & b) | c.
package settle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam int DEF_SETTLE_CYC  = 2;
    localparam int DEF_TIMEOUT_CYC = 15;

    function automatic logic ref_out(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

endpackage

// File: rtl/settle_ref.sv
// Combinational expected-value generator for the and-or lab circuit.
// Swap this module to check a different lab circuit with the same checker.
// Ports:
//   a, b, c  in   stimulus bits as applied to the device under test
//   exp_out  out  value the device output should settle to
module settle_ref
    import settle_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic exp_out
);

    assign exp_out = ref_out(a, b, c);

endmodule

// File: rtl/settle_checker.sv
// Receive-side settle checker for the and-or lab circuit.
// On every stimulus change it measures how many cycles the device output takes
// to settle to the expected value, reports pass/fail with the latency, and
// keeps running statistics.
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   in_a/b/c     stimulus vector as applied to the device under test
//   dut_out      device-under-test output
//   chk_valid    one-cycle result pulse; chk_pass/chk_lat/err_* valid with it
//   chk_pass     settled correctly
//   chk_lat      settle latency (first cycle of the qualifying run)
//   err_timeout  no qualifying run by TIMEOUT_CYC
//   err_abort    stimulus changed before settling
//   vec_cnt      vectors measured (saturating)
//   fail_cnt     failed vectors (saturating)
//   max_lat      largest passing latency since reset
module settle_checker
    import settle_pkg::*;
#(
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int LAT_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    input  logic             dut_out,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [LAT_W-1:0] chk_lat,
    output logic             err_timeout,
    output logic             err_abort,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [LAT_W-1:0] max_lat
);

    localparam int               RUN_W     = $clog2(SETTLE_CYC + 1);
    localparam logic [LAT_W-1:0] TIMEOUT_V = LAT_W'(TIMEOUT_CYC);
    localparam logic [RUN_W-1:0] SETTLE_V  = RUN_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       vec_now, vec_q;
    logic             change;
    logic             exp_now, exp_q, exp_d;
    logic [LAT_W-1:0] idx_q, idx_d;
    logic [LAT_W-1:0] mark_q, mark_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             match, qualify;
    logic             rpt_valid, rpt_pass, rpt_timeout, rpt_abort;
    logic [LAT_W-1:0] rpt_lat;

    assign vec_now = {in_a, in_b, in_c};
    assign change  = (vec_now != vec_q);

    // Expected value comes from the live inputs so it is ready in the change cycle.
    settle_ref u_ref (
        .a       (in_a),
        .b       (in_b),
        .c       (in_c),
        .exp_out (exp_now)
    );

    // Next-state and report decision. Priority within a cycle is
    // qualify, then timeout, then abort; a change always (re)starts MEAS
    // after whichever report the old vector earned.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        idx_d       = idx_q;
        mark_d      = mark_q;
        run_d       = run_q;
        rpt_valid   = 1'b0;
        rpt_pass    = 1'b0;
        rpt_timeout = 1'b0;
        rpt_abort   = 1'b0;
        rpt_lat     = '0;
        match       = (dut_out == exp_q);
        run_inc     = (run_q == SETTLE_V) ? run_q : run_q + RUN_W'(1);
        qualify     = 1'b0;

        if (state_q == MEAS) begin
            if (match) begin
                run_d = run_inc;
                if (run_q == '0) begin
                    mark_d = idx_q;
                end
                qualify = (run_inc == SETTLE_V);
            end else begin
                run_d = '0;
            end

            if (qualify) begin
                // mark_d, not mark_q: with SETTLE_CYC=1 the run starts this cycle.
                rpt_valid = 1'b1;
                rpt_pass  = 1'b1;
                rpt_lat   = mark_d;
                state_d   = IDLE;
            end else if (idx_q == TIMEOUT_V) begin
                rpt_valid   = 1'b1;
                rpt_timeout = 1'b1;
                rpt_lat     = TIMEOUT_V;
                state_d     = IDLE;
            end else if (change) begin
                rpt_valid = 1'b1;
                rpt_abort = 1'b1;
                rpt_lat   = idx_q;
            end else begin
                // idx_q < TIMEOUT_V here, so the increment cannot overflow.
                idx_d = idx_q + LAT_W'(1);
            end
        end

        if (change) begin
            state_d = MEAS;
            exp_d   = exp_now;
            idx_d   = LAT_W'(1);
            run_d   = '0;
        end
    end

    // State, measurement and registered report/statistics. vec_q is loaded
    // during reset so releasing reset with steady inputs raises no event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= vec_now;
            exp_q       <= 1'b0;
            idx_q       <= '0;
            mark_q      <= '0;
            run_q       <= '0;
            chk_valid   <= 1'b0;
            chk_pass    <= 1'b0;
            chk_lat     <= '0;
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
            vec_cnt     <= '0;
            fail_cnt    <= '0;
            max_lat     <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_now;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            mark_q      <= mark_d;
            run_q       <= run_d;
            chk_valid   <= rpt_valid;
            chk_pass    <= rpt_pass;
            err_timeout <= rpt_timeout;
            err_abort   <= rpt_abort;
            if (rpt_valid) begin
                chk_lat <= rpt_lat;
                if (vec_cnt != CNT_MAX) begin
                    vec_cnt <= vec_cnt + CNT_W'(1);
                end
                if (!rpt_pass && fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                if (rpt_pass && rpt_lat > max_lat) begin
                    max_lat <= rpt_lat;
                end
            end
        end
    end

endmodule
